// File: rtl/parity_check_rx.sv
// Serial frame receiver: deserialises DATA_W data bits (LSB first) plus one parity
// bit, flags parity mismatches and keeps a saturating parity-error count.
module parity_check_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sof_in,
  input  logic              bit_valid_in,
  input  logic              bit_in,
  input  logic              clr_err_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  output logic              parity_err_out,
  output logic              abort_out,
  output logic [CNT_W-1:0]  err_count_out
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mismatch;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    par_d    = par_q;
    word_d   = word_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    abort_d  = 1'b0;
    cnt_d    = cnt_q;
    mismatch = 1'b0;

    // Clear is applied first so an error completing on the same edge counts from zero.
    if (clr_err_in) begin
      cnt_d = '0;
    end

    if (bit_valid_in) begin
      if (sof_in) begin
        abort_d   = (state_q != IDLE);
        word_d    = '0;
        word_d[0] = bit_in;
        par_d     = bit_in;
        idx_d     = IDX_W'(1);
        state_d   = DATA;
      end else begin
        case (state_q)
          DATA: begin
            word_d[idx_q] = bit_in;
            par_d         = par_q ^ bit_in;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = PAR;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          PAR: begin
            mismatch = (bit_in != (par_q ^ ODD));
            data_d   = word_q;
            valid_d  = 1'b1;
            perr_d   = mismatch;
            if (mismatch && (cnt_d != {CNT_W{1'b1}})) begin
              cnt_d = cnt_d + CNT_W'(1);
            end
            idx_d   = '0;
            par_d   = 1'b0;
            state_d = IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      par_q   <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = valid_q;
  assign parity_err_out = perr_q;
  assign abort_out      = abort_q;
  assign err_count_out  = cnt_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Scoreboard bench for parity_check_rx: an even-parity receiver with a 2-bit error
// counter and an odd-parity receiver with an 8-bit counter share one serial stimulus.
module tb_parity_check_rx;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sof_in = 1'b0;
  logic bit_valid_in = 1'b0;
  logic bit_in = 1'b0;
  logic clr_err_in = 1'b0;

  logic [7:0] ev_data, od_data;
  logic       ev_valid, od_valid, ev_perr, od_perr, ev_abort, od_abort;
  logic [1:0] ev_cnt;
  logic [7:0] od_cnt;

  exp_t exp_even_q[$];
  exp_t exp_odd_q[$];
  int   abort_even_exp = 0;
  int   abort_odd_exp  = 0;
  int   cnt_even_model = 0;
  int   cnt_odd_model  = 0;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  parity_check_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(2)) dut_even (
    .clk(clk), .reset_n(reset_n), .sof_in(sof_in), .bit_valid_in(bit_valid_in),
    .bit_in(bit_in), .clr_err_in(clr_err_in), .data_out(ev_data),
    .data_valid_out(ev_valid), .parity_err_out(ev_perr), .abort_out(ev_abort),
    .err_count_out(ev_cnt)
  );

  parity_check_rx #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(8)) dut_odd (
    .clk(clk), .reset_n(reset_n), .sof_in(sof_in), .bit_valid_in(bit_valid_in),
    .bit_in(bit_in), .clr_err_in(clr_err_in), .data_out(od_data),
    .data_valid_out(od_valid), .parity_err_out(od_perr), .abort_out(od_abort),
    .err_count_out(od_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sof, input logic vld, input logic b, input logic clr);
    @(posedge clk);
    #2;
    sof_in       = sof;
    bit_valid_in = vld;
    bit_in       = b;
    clr_err_in   = clr;
  endtask

  // Pushes the hand-computed parity result for each receiver as the parity bit goes out.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic gap,
                            input logic err_even, input logic err_odd, input logic clr_at_par);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i == 0, 1'b1, d[i], 1'b0);
      if (gap) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (clr_at_par) begin
      cnt_even_model = 0;
      cnt_odd_model  = 0;
    end
    if (err_even && cnt_even_model < 3) cnt_even_model++;
    if (err_odd && cnt_odd_model < 255) cnt_odd_model++;
    e.data = d; e.perr = err_even; e.cnt = 8'(cnt_even_model);
    exp_even_q.push_back(e);
    e.data = d; e.perr = err_odd; e.cnt = 8'(cnt_odd_model);
    exp_odd_q.push_back(e);
    applyStimulus(1'b0, 1'b1, p, clr_at_par);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    checkOutput({tag, "_even_data"}, {24'd0, ev_data}, 32'd0);
    checkOutput({tag, "_even_flags"}, {29'd0, ev_valid, ev_perr, ev_abort}, 32'd0);
    checkOutput({tag, "_even_cnt"}, {30'd0, ev_cnt}, 32'd0);
    checkOutput({tag, "_odd_data"}, {24'd0, od_data}, 32'd0);
    checkOutput({tag, "_odd_flags"}, {29'd0, od_valid, od_perr, od_abort}, 32'd0);
    checkOutput({tag, "_odd_cnt"}, {24'd0, od_cnt}, 32'd0);
  endtask

  // Monitor: every valid pulse consumes one expectation; aborts are matched against a tally.
  always @(negedge clk) begin
    exp_t e;
    if (ev_valid) begin
      if (exp_even_q.size() == 0) begin
        checkOutput("even_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_even_q.pop_front();
        checkOutput("even_data", {24'd0, ev_data}, {24'd0, e.data});
        checkOutput("even_perr", {31'd0, ev_perr}, {31'd0, e.perr});
        checkOutput("even_cnt", {30'd0, ev_cnt}, {24'd0, e.cnt});
      end
    end else if (ev_perr) begin
      checkOutput("even_perr_without_valid", 32'd1, 32'd0);
    end
    if (od_valid) begin
      if (exp_odd_q.size() == 0) begin
        checkOutput("odd_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_odd_q.pop_front();
        checkOutput("odd_data", {24'd0, od_data}, {24'd0, e.data});
        checkOutput("odd_perr", {31'd0, od_perr}, {31'd0, e.perr});
        checkOutput("odd_cnt", {24'd0, od_cnt}, {24'd0, e.cnt});
      end
    end else if (od_perr) begin
      checkOutput("odd_perr_without_valid", 32'd1, 32'd0);
    end
    if (ev_abort) begin
      checkOutput("even_abort_expected", {31'd0, abort_even_exp > 0}, 32'd1);
      abort_even_exp--;
    end
    if (od_abort) begin
      checkOutput("odd_abort_expected", {31'd0, abort_odd_exp > 0}, 32'd1);
      abort_odd_exp--;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check_all_zero("reset");

    // 0xA5 has four ones.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort: sof plus three bits, then a fresh frame 0x3C (four ones) with parity 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    abort_even_exp++;
    abort_odd_exp++;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_even_consumed", abort_even_exp, 32'd0);
    checkOutput("abort_odd_consumed", abort_odd_exp, 32'd0);

    // Standalone clear, then saturation of the 2-bit counter, then clear plus error together.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cnt_even_model = 0;
    cnt_odd_model  = 0;
    @(negedge clk);
    checkOutput("clr_even_cnt", {30'd0, ev_cnt}, 32'd0);
    checkOutput("clr_odd_cnt", {24'd0, od_cnt}, 32'd0);
    for (int k = 0; k < 5; k++) send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset after four bits; the remaining bits arrive without sof and must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    bit_valid_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cnt_even_model = 0;
    cnt_odd_model  = 0;
    check_all_zero("midframe_reset");
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, k[0], 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    check_all_zero("after_ignored_bits");

    checkOutput("even_queue_empty", exp_even_q.size(), 32'd0);
    checkOutput("odd_queue_empty", exp_odd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Receive-side counterpart of the byte parity generator.
- Accepts a serial frame: DATA_W data bits, LSB first, followed by one parity bit.
- Deserialises the data bits into a word, checks the parity bit, and presents the word with a one-cycle valid pulse and an error flag.
- Keeps a saturating parity-error counter for status readout; sits between the serial link front-end and the byte consumer.

Parameters:
- DATA_W, 8, data bits per frame (>= 2).
- PARITY_ODD, 0, 0 = even parity (data plus parity bit has an even count of ones); 1 = odd parity.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- sof_in  input  1  start of frame; qualified by bit_valid_in; marks data bit 0.
- bit_valid_in  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data or parity bit.
- clr_err_in  input  1  clears err_count_out.
- data_out  output  DATA_W  last received word.
- data_valid_out  output  1  one-cycle pulse when a frame completes.
- parity_err_out  output  1  parity mismatch for the frame; meaningful only with data_valid_out.
- abort_out  output  1  one-cycle pulse when a frame is cut short by a new sof.
- err_count_out  output  CNT_W  saturating count of parity errors.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE; bit index and running parity = 0.
  - data_out, data_valid_out, parity_err_out, abort_out, err_count_out = 0.
  - Reset mid-frame discards the partial frame; no pulse is generated.
- Only cycles with bit_valid_in = 1 are acted on. Gaps of any length between bits are legal and do not change state.
- IDLE:
  - bit_valid_in with sof_in: capture bit_in as bit 0, running parity = bit_in, index = 1, go to DATA.
  - bit_valid_in without sof_in: ignored.
- DATA:
  - bit_valid_in without sof_in: store bit_in at position index, running parity ^= bit_in, index++.
  - After bit DATA_W-1 is stored, go to PAR.
- PAR:
  - bit_valid_in without sof_in: expected parity = running parity ^ PARITY_ODD; mismatch = (bit_in != expected). Go to IDLE.
  - At the same edge: data_out = assembled word, data_valid_out = 1, parity_err_out = mismatch.
  - If mismatch, err_count_out increments, saturating at 2^CNT_W-1.
- Latency: outputs update at the edge that samples the parity bit, so they are visible in the cycle after the parity bit is presented.
- data_valid_out and abort_out are single-cycle pulses. parity_err_out returns to 0 with data_valid_out. data_out holds until the next completed frame.
- sof_in with bit_valid_in while in DATA or PAR:
  - abort_out pulses for one cycle; the partial frame is discarded; data_out and the counter are unchanged.
  - The bit is taken as bit 0 of a new frame: index = 1, running parity = bit_in, state = DATA.
- clr_err_in:
  - Counter = 0 at the next edge.
  - If a parity error completes at the same edge, counter = 1 (clear first, then count).
  - Reset has priority over clr_err_in.
- Internal index width: clog2(DATA_W). The index must not wrap inside a frame.

Test Plan:
- Even parity, DATA_W = 8: sof, bits of 0xA5 LSB first, parity bit 0 -> one cycle later data_out = 0xA5, data_valid_out = 1 for 1 cycle, parity_err_out = 0, err_count_out = 0.
- Same frame with parity bit 1 -> data_out = 0xA5, parity_err_out = 1 with the valid pulse, err_count_out = 1. Repeat with bit_valid_in toggling every other cycle -> identical result.
- PARITY_ODD = 1: frame 0x01 with parity bit 0 -> parity_err_out = 0. Frame 0x03 with parity bit 0 -> parity_err_out = 1.
- Abort: sof plus 3 bits, then sof with 0x3C and parity 0 (even) -> abort_out pulses once at the second sof; one valid pulse follows with data_out = 0x3C and no error.
- CNT_W = 2: five bad-parity frames -> err_count_out = 1, 2, 3, 3, 3. clr_err_in on the same edge as a sixth bad frame -> err_count_out = 1.
- reset_n low for 1 cycle after 4 bits of a frame -> all outputs 0. Remaining bits without sof are ignored; no valid pulse.
